bus_inv_dec: RTL and testbench

Bus-invert decoder and checker for a WIDTH-bit parallel link. It receives words encoded with bus-invert coding, where the transmitter sends either the data or its bitwise inverse and raises a flag line. It restores the original data, verifies that the transmitter chose the minimum-transition encoding, and counts violations. It sits at the receiving end of the link, ahead of downstream consumers, as a single registered stage with valid/ready flow control.

---
 rtl/bus_inv_dec.sv | 86 ++++++++
 tb/tb_bus_inv_dec.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/bus_inv_dec.sv
// Bus-invert decoder/checker: restores data from a bus-invert coded link, flags
// words where the transmitter did not pick the minimum-transition encoding.
module bus_inv_dec #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_bus,
  input  logic             i_inv,
  input  logic             i_vld,
  output logic             o_rdy,
  output logic [WIDTH-1:0] o_y,
  output logic             o_err,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [CNT_W-1:0] o_err_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] HALF = CW'(WIDTH / 2);

  function automatic logic [CW-1:0] f_popcount(input logic [WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int k = 0; k < WIDTH; k++) begin
      c = c + CW'(v[k]);
    end
    return c;
  endfunction

  logic [WIDTH-1:0] r_prev;
  logic [WIDTH-1:0] r_y;
  logic             r_err;
  logic             r_vld;
  logic [CNT_W-1:0] r_cnt;

  logic             w_acc;
  logic             w_drain;
  logic [WIDTH-1:0] w_d;
  logic [CW-1:0]    w_hd;
  logic             w_exp_inv;
  logic             w_viol;
  logic             w_cnt_max;

  assign o_rdy     = !r_vld || i_rdy;
  assign w_acc     = i_vld && o_rdy;
  assign w_drain   = r_vld && i_rdy && !w_acc;

  // Transitions are measured on the decoded word against the previous raw link state.
  assign w_d       = i_inv ? ~i_bus : i_bus;
  assign w_hd      = f_popcount(w_d ^ r_prev);
  assign w_exp_inv = (w_hd > HALF);
  assign w_viol    = (i_inv != w_exp_inv);
  assign w_cnt_max = &r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prev <= '0;
      r_y    <= '0;
      r_err  <= 1'b0;
      r_vld  <= 1'b0;
    end else if (w_acc) begin
      r_prev <= i_bus;
      r_y    <= w_d;
      r_err  <= w_viol;
      r_vld  <= 1'b1;
    end else if (w_drain) begin
      r_vld  <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_acc && w_viol && !w_cnt_max) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_y       = r_y;
  assign o_err     = r_err;
  assign o_vld     = r_vld;
  assign o_err_cnt = r_cnt;

endmodule

// File: tb/tb_bus_inv_dec.sv
// Randomized + directed bench for bus_inv_dec; two instances (8-bit and 2-bit
// counter) share stimulus and are checked every cycle against a behavioural model.
module tb_bus_inv_dec;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic [W-1:0] bus;
  logic         inv;
  logic         vld;
  logic         rdy;

  logic         a_rdy, a_err, a_vld;
  logic [W-1:0] a_y;
  logic [7:0]   a_cnt;
  logic         b_rdy, b_err, b_vld;
  logic [W-1:0] b_y;
  logic [1:0]   b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  bus_inv_dec #(.WIDTH(W), .CNT_W(8)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_bus(bus), .i_inv(inv), .i_vld(vld),
    .o_rdy(a_rdy), .o_y(a_y), .o_err(a_err), .o_vld(a_vld), .i_rdy(rdy),
    .o_err_cnt(a_cnt)
  );

  bus_inv_dec #(.WIDTH(W), .CNT_W(2)) u_sat (
    .i_clk(clk), .i_rst(rst), .i_bus(bus), .i_inv(inv), .i_vld(vld),
    .o_rdy(b_rdy), .o_y(b_y), .o_err(b_err), .o_vld(b_vld), .i_rdy(rdy),
    .o_err_cnt(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the link state and the word the receiver should be holding.
  logic [W-1:0] m_prev, m_y;
  logic         m_err, m_vld;
  int           m_cnt8, m_cnt2;
  bit           started = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_prev = '0; m_y = '0; m_err = 0; m_vld = 0; m_cnt8 = 0; m_cnt2 = 0;
      started = 1;
    end else if (vld && (!m_vld || rdy)) begin
      logic [W-1:0] d;
      int hd;
      bit exp_inv, viol;
      d = inv ? ~bus : bus;
      hd = $countones(d ^ m_prev);
      exp_inv = (hd > W / 2);
      viol = (inv != exp_inv);
      m_y = d; m_err = viol; m_vld = 1; m_prev = bus;
      if (viol) begin
        m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end else if (m_vld && rdy) begin
      m_vld = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("rdy",    int'(a_rdy), int'(!m_vld || rdy));
      chk("y",      int'(a_y),   int'(m_y));
      chk("err",    int'(a_err), int'(m_err));
      chk("vld",    int'(a_vld), int'(m_vld));
      chk("cnt8",   int'(a_cnt), m_cnt8);
      chk("s_rdy",  int'(b_rdy), int'(!m_vld || rdy));
      chk("s_y",    int'(b_y),   int'(m_y));
      chk("s_err",  int'(b_err), int'(m_err));
      chk("s_vld",  int'(b_vld), int'(m_vld));
      chk("cnt2",   int'(b_cnt), m_cnt2);
    end
  end

  // Apply inputs shortly after a rising edge, then wait through the next edge.
  task automatic cyc(input logic [W-1:0] b, input logic iv, input logic v,
                     input logic r, input logic rs);
    bus = b; inv = iv; vld = v; rdy = r; rst = rs;
    @(posedge clk); #2;
  endtask

  initial begin
    bus = '0; inv = 0; vld = 0; rdy = 1; rst = 1;
    @(posedge clk); #2;

    // tie, no inversion
    cyc(8'h0F, 0, 1, 1, 0);
    chk("t1_y", int'(a_y), 'h0F);
    chk("t1_vld", int'(a_vld), 1);
    chk("t1_err", int'(a_err), 0);
    chk("t1_cnt", int'(a_cnt), 0);

    // valid inversion against prev=0x0F
    cyc(8'h0F, 1, 1, 1, 0);
    chk("t2_y", int'(a_y), 'hF0);
    chk("t2_err", int'(a_err), 0);

    // two violations from reset
    cyc(8'h00, 0, 0, 1, 1);
    cyc(8'hFF, 1, 1, 1, 0);
    chk("t3a_y", int'(a_y), 'h00);
    chk("t3a_err", int'(a_err), 1);
    chk("t3a_cnt", int'(a_cnt), 1);
    cyc(8'h00, 0, 1, 1, 0);
    chk("t3b_y", int'(a_y), 'h00);
    chk("t3b_err", int'(a_err), 1);
    chk("t3b_cnt", int'(a_cnt), 2);

    // backpressure
    bus = 8'h33; inv = 0; vld = 1; rdy = 0; #1;
    chk("t4_rdy_stall", int'(a_rdy), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(8'h33, 0, 1, 0, 0);
      chk("t4_hold_y", int'(a_y), 'h00);
      chk("t4_hold_vld", int'(a_vld), 1);
      chk("t4_hold_rdy", int'(a_rdy), 0);
    end
    cyc(8'h33, 0, 1, 1, 0);
    chk("t4_y", int'(a_y), 'h33);
    chk("t4_err", int'(a_err), 0);
    for (int i = 0; i < 6; i++) begin
      cyc(W'($urandom), 1'($urandom), 1, 1, 0);
      chk("t4_b2b_vld", int'(a_vld), 1);
    end

    // saturation of the 2-bit counter with alternating violations
    cyc(8'h00, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) cyc(8'hFF, 1, 1, 1, 0);
      else            cyc(8'h00, 0, 1, 1, 0);
      chk("t5_err", int'(b_err), 1);
      chk("t5_cnt2", int'(b_cnt), (i < 3) ? i + 1 : 3);
      chk("t5_cnt8", int'(a_cnt), i + 1);
    end

    // reset mid-stream
    cyc(8'h55, 0, 1, 1, 1);
    chk("t6_vld", int'(a_vld), 0);
    chk("t6_cnt", int'(a_cnt), 0);
    chk("t6_y", int'(a_y), 0);
    cyc(8'h0F, 0, 1, 1, 0);
    chk("t6_err", int'(a_err), 0);
    chk("t6_y2", int'(a_y), 'h0F);

    // random traffic, long reset-free run first so the 8-bit counter saturates
    for (int i = 0; i < 3000; i++) begin
      logic rs;
      rs = (i > 2000) && ($urandom_range(99) == 0);
      cyc(W'($urandom), 1'($urandom), ($urandom_range(9) < 7), ($urandom_range(9) < 7), rs);
    end
    cyc(8'h00, 0, 0, 1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
